// File: rtl/md_unit.sv
// Iterative multiply/divide unit: shift-add multiply (LSB-first) and restoring divide, WIDTH-generic.
// Optional macro MD_EARLY_OUT_EN lets a multiply finish once the remaining multiplier is zero.
module md_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic                 busy,
    output logic                 ready,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   result
);
    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_p_q, neg_p_d;
    logic                 neg_r_q, neg_r_d;
    // Multiply: acc = product. Divide: acc = {rem, quot}, quot initially holds the dividend.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiply: shifting multiplicand. Divide: divisor in the low half.
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 neg1, neg2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   mul_acc, div_acc, step_acc, corr_acc;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     mplier_sh;
    logic                 last;

    assign neg1 = op[0] & opdata1[WIDTH-1];
    assign neg2 = op[0] & opdata2[WIDTH-1];
    assign mag1 = neg1 ? -opdata1 : opdata1;
    assign mag2 = neg2 ? -opdata2 : opdata2;

    always_comb begin
        mul_acc = mplier_q[0] ? acc_q + mcand_q : acc_q;
        div_acc = {acc_q[2*WIDTH-2:0], 1'b0};
        trial   = {1'b0, div_acc[2*WIDTH-1:WIDTH]} - {1'b0, mcand_q[WIDTH-1:0]};
        if (!trial[WIDTH]) begin
            div_acc[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
            div_acc[0]               = 1'b1;
        end
        step_acc  = is_div_q ? div_acc : mul_acc;
        mplier_sh = mplier_q >> 1;
        // Sign correction applied on the edge that enters DONE.
        corr_acc = step_acc;
        if (is_div_q) begin
            if (neg_p_q) corr_acc[WIDTH-1:0] = -step_acc[WIDTH-1:0];
            if (neg_r_q) corr_acc[2*WIDTH-1:WIDTH] = -step_acc[2*WIDTH-1:WIDTH];
        end else if (neg_p_q) begin
            corr_acc = -step_acc;
        end
    end

`ifdef MD_EARLY_OUT_EN
    assign last = (cnt_q == LastCnt) || (!is_div_q && mplier_sh == '0);
`else
    assign last = (cnt_q == LastCnt);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_p_d    = neg_p_q;
        neg_r_d    = neg_r_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (op[1] && opdata2 == '0) begin
                        state_d    = StDone;
                        ready_d    = 1'b1;
                        div_zero_d = 1'b1;
                        result_d   = '0;
                    end else begin
                        state_d  = StBusy;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        neg_p_d  = neg1 ^ neg2;
                        neg_r_d  = neg1;
                        mplier_d = mag2;
                        if (op[1]) begin
                            acc_d   = {{WIDTH{1'b0}}, mag1};
                            mcand_d = {{WIDTH{1'b0}}, mag2};
                        end else begin
                            acc_d   = '0;
                            mcand_d = {{WIDTH{1'b0}}, mag1};
                        end
                    end
                end
            end
            StBusy: begin
                acc_d    = step_acc;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + CntW'(1);
                if (!is_div_q) mcand_d = mcand_q << 1;
                if (last) begin
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                    result_d = corr_acc;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d    = StIdle;
                    ready_d    = 1'b0;
                    div_zero_d = 1'b0;
                    result_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (annul) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            ready_d    = 1'b0;
            div_zero_d = 1'b0;
            result_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_p_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_p_q    <= neg_p_d;
            neg_r_q    <= neg_r_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign div_zero = div_zero_q;
    assign result   = result_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32); follows MD_EARLY_OUT_EN if defined.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        annul;
    logic [31:0] opdata1, opdata2;
    logic        busy, ready, div_zero;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .annul    (annul),
        .opdata1  (opdata1),
        .opdata2  (opdata2),
        .busy     (busy),
        .ready    (ready),
        .div_zero (div_zero),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected BUSY cycles for a multiply given the multiplier magnitude.
    function automatic int mul_busy(input logic [31:0] mag);
        int n;
`ifdef MD_EARLY_OUT_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
`else
        n = 32;
`endif
        return n;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        opdata1 = a;
        opdata2 = b;
    endtask

    // Cycles from start sampled to ready visible, plus BUSY cycles seen on the way.
    task automatic wait_done(output int lat, output int nbusy);
        bit done = 0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) nbusy++;
            if (ready) done = 1;
        end
        if (!done) check_eq("timeout", 64'd0, 64'd1);
    endtask

    task automatic release_start(input string tag);
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ready_drop"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        int lat, nbusy;
        bit any_ready;
        rst = 1'b0; start = 1'b0; op = 2'b00; annul = 1'b0; opdata1 = '0; opdata2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_ready", {63'd0, ready}, 64'd0);
        check_eq("rst_result", result, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // divu 100/7
        launch(2'b10, 32'd100, 32'd7);
        wait_done(lat, nbusy);
        check_eq("divu_lat", 64'(lat), 64'd33);
        check_eq("divu_busy", 64'(nbusy), 64'd32);
        check_eq("divu_res", result, {32'd2, 32'd14});
        check_eq("divu_dz", {63'd0, div_zero}, 64'd0);
        release_start("divu");
        @(negedge clk);

        // div -7/2
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, nbusy);
        check_eq("div_neg_res", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_start("div_neg");
        @(negedge clk);

        // div 7/-2: remainder follows dividend sign
        launch(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, nbusy);
        check_eq("div_negd_res", result, {32'd1, 32'hFFFF_FFFD});
        release_start("div_negd");
        @(negedge clk);

        // div overflow -2^31 / -1
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nbusy);
        check_eq("div_ovf_res", result, {32'd0, 32'h8000_0000});
        release_start("div_ovf");
        @(negedge clk);

        // mul signed -1 * 2
        launch(2'b01, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat, nbusy);
        check_eq("mul_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("mul_busy", 64'(nbusy), 64'(mul_busy(32'd2)));
        release_start("mul");
        @(negedge clk);

        // mulu same operands
        launch(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat, nbusy);
        check_eq("mulu_res", result, 64'h0000_0001_FFFF_FFFE);
        check_eq("mulu_busy", 64'(nbusy), 64'(mul_busy(32'd2)));
        release_start("mulu");
        @(negedge clk);

        // mul signed -2^31 * -1
        launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nbusy);
        check_eq("mul_min_res", result, 64'h0000_0000_8000_0000);
        check_eq("mul_min_busy", 64'(nbusy), 64'(mul_busy(32'd1)));
        release_start("mul_min");
        @(negedge clk);

        // mulu 5*3
        launch(2'b00, 32'd5, 32'd3);
        wait_done(lat, nbusy);
        check_eq("mulu53_res", result, 64'd15);
        check_eq("mulu53_busy", 64'(nbusy), 64'(mul_busy(32'd3)));
        release_start("mulu53");
        @(negedge clk);

        // mulu by zero
        launch(2'b00, 32'd7, 32'd0);
        wait_done(lat, nbusy);
        check_eq("mulu0_res", result, 64'd0);
        check_eq("mulu0_busy", 64'(nbusy), 64'(mul_busy(32'd0)));
        release_start("mulu0");
        @(negedge clk);

        // divu 5/0, held for 5 cycles
        launch(2'b10, 32'd5, 32'd0);
        wait_done(lat, nbusy);
        check_eq("dz_lat", 64'(lat), 64'd1);
        check_eq("dz_busy", 64'(nbusy), 64'd0);
        check_eq("dz_res", result, 64'd0);
        check_eq("dz_flag", {63'd0, div_zero}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("dz_hold", {result, ready, div_zero} != {64'd0, 1'b1, 1'b1} ? 64'd1 : 64'd0,
                     64'd0);
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("dz_drop_ready", {63'd0, ready}, 64'd0);
        check_eq("dz_drop_flag", {63'd0, div_zero}, 64'd0);
        @(negedge clk);

        // annul at BUSY cycle 10
        launch(2'b10, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        check_eq("annul_pre_busy", {63'd0, busy}, 64'd1);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("annul_busy", {63'd0, busy}, 64'd0);
        check_eq("annul_ready", {63'd0, ready}, 64'd0);
        check_eq("annul_result", result, 64'd0);
        annul = 1'b0;
        any_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready || busy) any_ready = 1;
        end
        check_eq("annul_quiet", {63'd0, any_ready}, 64'd0);
        launch(2'b10, 32'd9, 32'd3);
        wait_done(lat, nbusy);
        check_eq("post_annul_res", result, {32'd0, 32'd3});
        check_eq("post_annul_lat", 64'(lat), 64'd33);
        release_start("post_annul");
        @(negedge clk);

        // reset mid-BUSY
        launch(2'b10, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rstb_outs", {result, busy, ready, div_zero} != '0 ? 64'd1 : 64'd0, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // reset mid-DONE
        launch(2'b10, 32'd5, 32'd0);
        @(negedge clk);
        check_eq("rstd_pre_ready", {63'd0, ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstd_ready", {63'd0, ready}, 64'd0);
        check_eq("rstd_dz", {63'd0, div_zero}, 64'd0);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rstd_no_residual", {63'd0, ready}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
